// File: rtl/i2c_slave_rx.sv
// Receive-only I2C slave: oversamples scl/sda, ACKs its own address and hands
// received data bytes out over valid/ready. `I2C_RX_GCALL_EN also accepts general call.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    ACK_A  = 3'd2,
    DATA   = 3'd3,
    ACK_D  = 3'd4,
    NACK   = 3'd5,
    IGNORE = 3'd6
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0]             byte_s;
  logic                   addr_hit_s, gcall_hit_s;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] sreg_q, sreg_d;
  logic       ack_ph_q, ack_ph_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;
  logic       busy_q, busy_d;

  // Synchronizers plus edge-detect stage; idle bus level is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_prev_q;
  assign scl_fall_s = ~scl_s & scl_prev_q;
  assign start_s    = scl_s & sda_prev_q & ~sda_s;
  assign stop_s     = scl_s & ~sda_prev_q & sda_s;
  assign byte_s     = {sreg_q, sda_s};

`ifdef I2C_RX_GCALL_EN
  assign gcall_hit_s = (byte_s[7:1] == 7'h00);
`else
  assign gcall_hit_s = 1'b0;
`endif
  assign addr_hit_s = ((byte_s[7:1] == SLAVE_ADDR) | gcall_hit_s) & ~byte_s[0];

  // Protocol state register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      sreg_q     <= 7'h00;
      ack_ph_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sreg_q     <= sreg_d;
      ack_ph_q   <= ack_ph_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic; ack_ph marks that the ACK clock itself is in progress.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sreg_d     = sreg_q;
    ack_ph_d   = ack_ph_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    overrun_d  = overrun_q;
    busy_d     = busy_q;
    if (stop_s) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      ack_ph_d  = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_s) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      ack_ph_d  = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        ADDR, DATA: begin
          if (scl_rise_s) begin
            sreg_d = byte_s[6:0];
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = 3'd0;
              ack_ph_d  = 1'b0;
              if (state_q == ADDR) begin
                state_d = addr_hit_s ? ACK_A : IGNORE;
              end else if (rx_ready) begin
                rx_data_d  = byte_s;
                rx_valid_d = 1'b1;
                state_d    = ACK_D;
              end else begin
                overrun_d = 1'b1;
                state_d   = NACK;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            sreg_d = sreg_q;
          end
        end
        ACK_A, ACK_D, NACK: begin
          if (scl_fall_s) begin
            if (!ack_ph_q) begin
              ack_ph_d = 1'b1;
              sda_oe_d = (state_q != NACK);
            end else begin
              ack_ph_d  = 1'b0;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = (state_q == NACK) ? IGNORE : DATA;
            end
          end else begin
            ack_ph_d = ack_ph_q;
          end
        end
        IDLE, IGNORE: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Self-checking bench for i2c_slave_rx: table of frames plus hand-written
// repeated-START and mid-ACK reset sequences; received bytes go through a scoreboard.
module tb_i2c_slave_rx;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_in, sda_oe, rx_valid, rx_ready, overrun, busy;
  logic [7:0] rx_data;

  assign sda_in = sda_m & ~sda_oe;

  i2c_slave_rx dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl_m),
    .sda_in   (sda_in),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data;
    logic       ready;
    logic       exp_aack;
    logic       exp_dack;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] sb_q[$];
  int         n_vec = 0;
  int         n_mis = 0;
  int         n_valid = 0;
  int         cur = 0;
  logic       ovr_model = 1'b0;
  logic [7:0] last_rx = 8'h00;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s (vec %0d): got %h, required %h", nm, cur, act, exp);
    end
  endtask

  // Scoreboard: every rx_valid pulse must match the next expected byte.
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL unexpected_valid (vec %0d): got %h, required no pulse", cur, rx_data);
      end else begin
        check("rx_data", rx_data, sb_q.pop_front());
        last_rx = rx_data;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_c();
    sda_m = 1'b1; tick(H);
    scl_m = 1'b1; tick(H);
    sda_m = 1'b0; tick(H);
    scl_m = 1'b0; tick(H);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; tick(H);
    scl_m = 1'b1; tick(H);
    sda_m = 1'b1; tick(H);
  endtask

  task automatic bit_c(input logic b);
    sda_m = b;    tick(H);
    scl_m = 1'b1; tick(H);
    scl_m = 1'b0; tick(H);
  endtask

  task automatic byte_c(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bit_c(b[i]);
  endtask

  task automatic ack_c(output logic seen);
    sda_m = 1'b1; tick(H);
    scl_m = 1'b1; tick(H / 2);
    seen = sda_oe;
    tick(H / 2);
    scl_m = 1'b0; tick(H);
  endtask

  task automatic full_frame(input logic [6:0] a, input logic rw, input logic [7:0] d,
                            input logic rdy, input logic e_aack, input logic e_dack);
    logic seen;
    start_c();
    check("busy_after_start", {7'd0, busy}, 8'h01);
    byte_c({a, rw});
    ack_c(seen);
    check("addr_ack", {7'd0, seen}, {7'd0, e_aack});
    rx_ready = rdy;
    if (e_aack && rdy) sb_q.push_back(d);
    if (e_aack && !rdy) ovr_model = 1'b1;
    byte_c(d);
    rx_ready = 1'b1;
    ack_c(seen);
    check("data_ack", {7'd0, seen}, {7'd0, e_dack});
    stop_c();
    tick(4);
    check("busy_after_stop", {7'd0, busy}, 8'h00);
    check("overrun", {7'd0, overrun}, {7'd0, ovr_model});
    check("rx_data_hold", rx_data, last_rx);
  endtask

  initial begin
    logic seen;
    int   v0;
    vecs[0] = '{7'h42, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{7'h13, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{7'h42, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0};
`ifdef I2C_RX_GCALL_EN
    vecs[3] = '{7'h00, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b1};
`else
    vecs[3] = '{7'h00, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0};
`endif
    vecs[4] = '{7'h42, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{7'h42, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};

    rx_ready = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(2);
    check("rst_sda_oe", {7'd0, sda_oe}, 8'h00);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
    check("rst_overrun", {7'd0, overrun}, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);

    for (int i = 0; i < 6; i++) begin
      cur = i;
      full_frame(vecs[i].addr, vecs[i].rw, vecs[i].data, vecs[i].ready,
                 vecs[i].exp_aack, vecs[i].exp_dack);
    end

    // Partial byte cut off by a repeated START must not be delivered.
    cur = 6;
    v0 = n_valid;
    start_c();
    byte_c(8'h84);
    ack_c(seen);
    check("rs_addr_ack", {7'd0, seen}, 8'h01);
    bit_c(1'b1); bit_c(1'b0); bit_c(1'b1); bit_c(1'b1);
    start_c();
    byte_c(8'h84);
    ack_c(seen);
    check("rs_addr2_ack", {7'd0, seen}, 8'h01);
    sb_q.push_back(8'h81);
    byte_c(8'h81);
    ack_c(seen);
    check("rs_data_ack", {7'd0, seen}, 8'h01);
    stop_c();
    tick(4);
    check("rs_valid_count", 8'(n_valid - v0), 8'h01);

    // Reset while the slave is driving an ACK.
    cur = 7;
    start_c();
    byte_c(8'h84);
    sda_m = 1'b1; tick(H);
    scl_m = 1'b1; tick(H / 2);
    check("pre_rst_sda_oe", {7'd0, sda_oe}, 8'h01);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_ack_sda_oe", {7'd0, sda_oe}, 8'h00);
    ovr_model = 1'b0;
    last_rx = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    tick(H / 2);
    scl_m = 1'b0; tick(H);
    check("rst_mid_ack_busy", {7'd0, busy}, 8'h00);
    stop_c();
    cur = 8;
    full_frame(7'h42, 1'b0, 8'h11, 1'b1, 1'b1, 1'b1);

    tick(4);
    check("sb_empty", 8'(sb_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
Receive-only I2C slave that sits directly downstream of the I2C master transmitter and consumes its sda/scl lines.
- Oversamples scl/sda on the system clock.
- Detects START/STOP, shifts in the address and data bytes, and ACKs bytes addressed to it.
- Hands each received data byte to the local consumer over a valid/ready handshake.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit address this slave answers to.
- SYNC_STAGES, 2, synchronizer flop depth on scl and sda (legal values 2..4).

Ports:
- clk  input  1  system clock; must be at least 8x the scl rate
- rst  input  1  synchronous, active-high reset
- scl  input  1  I2C clock line from the master
- sda_in  input  1  I2C data line as observed on the bus
- sda_oe  output  1  1 = pull sda low (ACK); 0 = release
- rx_data  output  8  last received data byte, MSB first on the wire
- rx_valid  output  1  one-clk pulse: rx_data holds a new byte
- rx_ready  input  1  consumer can accept a byte this cycle
- overrun  output  1  sticky; byte dropped because rx_ready was low
- busy  output  1  high from START to STOP

Behaviour:
Reset values:
- sda_oe=0, rx_data=8'h00, rx_valid=0, overrun=0, busy=0.
- State IDLE, bit_cnt=0; synchronizer flops set to 1 (idle bus level).

Sampling and edge detection:
- scl and sda each pass through SYNC_STAGES flops, then one extra register for edge detection.
- Any pin change is therefore acted on SYNC_STAGES+1 clks later (3 clk at default).
- scl_rise / scl_fall are derived from the synchronized scl.
- START = synchronized sda falls while synchronized scl=1.
- STOP = synchronized sda rises while synchronized scl=1.

Bit capture:
- Data bits are sampled on scl_rise into an 8-bit shift register, MSB first.
- bit_cnt counts 0..7.

States:
- IDLE: wait for START; then enter ADDR, set bit_cnt=0, busy=1.
- ADDR: shift 8 bits (7 address bits + R/W). After the 8th scl_rise, compare sreg[7:1] with SLAVE_ADDR:
  - match and R/W=0 -> ACK_A
  - otherwise (mismatch, or R/W=1 because this block is receive-only) -> IGNORE
- ACK_A:
  - On the first scl_fall, assert sda_oe.
  - Hold sda_oe through the ACK clock; release on the next scl_fall.
  - Then enter DATA with bit_cnt=0.
- DATA: shift 8 bits. On the 8th scl_rise, latch the byte.
  - If rx_ready=1 in that cycle: rx_data<=byte, rx_valid=1 for exactly one clk, go to ACK_D.
  - If rx_ready=0: rx_data is unchanged, overrun<=1, go to NACK.
- ACK_D: same sda_oe timing as ACK_A, then return to DATA.
- NACK: sda_oe stays 0 for the ACK clock; after that ACK clock's scl_fall, go to IGNORE.
- IGNORE: sda_oe=0; wait for START or STOP.

Global transition rules:
- STOP in any state -> IDLE; busy=0, sda_oe=0 in the same clk.
- START (including repeated START) in any state -> ADDR; bit_cnt=0, sda_oe=0.
- START/STOP take priority over a simultaneous scl edge.
- Bits from an incomplete byte are discarded on START/STOP; no rx_valid is issued.

Other rules:
- overrun is cleared only by rst.
- A reset asserted mid-transfer takes effect on the next clk edge. sda_oe is released immediately, and the slave ignores the bus until the next START.
- sda_oe never changes while synchronized scl=1, except when forced to 0 by a STOP or START.

Optional Feature:
I2C_RX_GCALL_EN
- Defined: address 7'h00 with R/W=0 (general call) is also treated as a match. It is ACKed and its data bytes are delivered exactly like own-address bytes.
- Not defined: 7'h00 is treated as a mismatch and goes to IGNORE.

Test Plan:
- Reset, then drive START, addr 0x42, W, data 0xA5, STOP with rx_ready=1:
  - sda_oe asserted for both ACK clocks.
  - One rx_valid pulse with rx_data=0xA5.
  - busy 1->0 after STOP; overrun=0.
- START, addr 0x13, W, data 0xFF, STOP -> sda_oe stays 0 throughout, no rx_valid, state returns to IDLE.
- START, addr 0x42, W, data 0x3C with rx_ready=0 at the 8th bit -> NACK (sda_oe=0 in the ACK clock), overrun=1, rx_data unchanged, no rx_valid.
- START, 0x42 W, 4 data bits, repeated START, 0x42 W, data 0x81, STOP -> partial byte discarded, exactly one rx_valid with 0x81.
- START, 0x42, R/W=1 -> no ACK, IGNORE until STOP; with I2C_RX_GCALL_EN, START, 0x00 W, 0x5A -> ACK and rx_data=0x5A.
- Assert rst while sda_oe=1 during an ACK -> sda_oe=0 on the next clk; the following full 0x42/0x11 frame is received correctly.
